// File: rtl/pipe_addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Saturation limits are returned wide and truncated to WIDTH by the user.
package pipe_addsub_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;
    localparam int MAX_WIDTH     = 256;

    function automatic int calcStages(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] satMax(input int width);
        return (MAX_WIDTH'(1) << (width - 1)) - MAX_WIDTH'(1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] satMin(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/pipe_addsub_chunk.sv
// Combinational W-bit ripple segment; also exposes the carry into its top bit
// so the final segment can derive signed overflow.
module addsub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W-1:0] w_low;

    // Lower W-1 bits plus carry-in; the spare top bit becomes the carry into the MSB.
    assign w_low    = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + W'(cin);
    assign c_msb_in = w_low[W-1];
    assign sum      = {a[W-1] ^ b[W-1] ^ c_msb_in, w_low[W-2:0]};
    assign cout     = (a[W-1] & b[W-1]) | (c_msb_in & (a[W-1] ^ b[W-1]));

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit add/sub, one CHUNK-bit segment per stage, valid/ready flow control.
// Optional saturation on signed overflow is enabled by defining PIPE_ADDSUB_SAT_EN.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
`ifdef PIPE_ADDSUB_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STAGES = calcStages(WIDTH, CHUNK);
`ifdef PIPE_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(satMax(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(satMin(WIDTH));
`endif

    logic [STAGES:0]  w_ready;
    logic [WIDTH-1:0] w_bIn;

    assign w_bIn           = in_sub ? ~in_b : in_b;
    assign w_ready[STAGES] = out_ready;
    assign in_ready        = reset_n & w_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W = WIDTH - k * CHUNK;
        localparam int REM_W = SRC_W - CHUNK;

        logic                   w_prevValid, w_cin, w_cout, w_cMsb, w_load;
        logic [SRC_W-1:0]       w_srcA, w_srcB;
        logic [CHUNK-1:0]       w_sumChunk;
        logic [(k+1)*CHUNK-1:0] w_sumIn, w_sumNext;
        logic                   r_valid, r_c;
        logic [(k+1)*CHUNK-1:0] r_sum;
`ifdef PIPE_ADDSUB_SAT_EN
        logic                   w_satIn;
`endif

        // Stage 0 takes the operands directly; later stages take the skewed upper chunks.
        if (k == 0) begin : g_first
            assign w_prevValid = in_valid;
            assign w_cin       = in_sub;
            assign w_srcA      = in_a;
            assign w_srcB      = w_bIn;
            assign w_sumIn     = w_sumChunk;
`ifdef PIPE_ADDSUB_SAT_EN
            assign w_satIn     = in_sat;
`endif
        end else begin : g_next
            assign w_prevValid = g_stage[k-1].r_valid;
            assign w_cin       = g_stage[k-1].r_c;
            assign w_srcA      = g_stage[k-1].g_skew.r_a;
            assign w_srcB      = g_stage[k-1].g_skew.r_b;
            assign w_sumIn     = {w_sumChunk, g_stage[k-1].r_sum};
`ifdef PIPE_ADDSUB_SAT_EN
            assign w_satIn     = g_stage[k-1].g_skew.r_sat;
`endif
        end

        assign w_ready[k] = ~r_valid | w_ready[k+1];
        assign w_load     = w_ready[k] & w_prevValid;

        addsub_chunk #(.W(CHUNK)) u_chunk (
            .a        (w_srcA[CHUNK-1:0]),
            .b        (w_srcB[CHUNK-1:0]),
            .cin      (w_cin),
            .sum      (w_sumChunk),
            .cout     (w_cout),
            .c_msb_in (w_cMsb)
        );

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_valid <= 1'b0;
                r_c     <= 1'b0;
                r_sum   <= '0;
            end else begin
                if (w_ready[k])
                    r_valid <= w_prevValid;
                if (w_load) begin
                    r_c   <= w_cout;
                    r_sum <= w_sumNext;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic w_ovf;
            logic r_ovf, r_zero;

            assign w_ovf = w_cout ^ w_cMsb;
`ifdef PIPE_ADDSUB_SAT_EN
            // Raw MSB set after overflow means the true result was positive.
            assign w_sumNext = (w_satIn && w_ovf) ? (w_sumIn[WIDTH-1] ? SAT_MAX : SAT_MIN)
                                                  : w_sumIn;
`else
            assign w_sumNext = w_sumIn;
`endif

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_load) begin
                    r_ovf  <= w_ovf;
                    r_zero <= (w_sumIn == '0);
                end
            end
        end else begin : g_skew
            logic [REM_W-1:0] r_a, r_b;
`ifdef PIPE_ADDSUB_SAT_EN
            logic             r_sat;
`endif

            assign w_sumNext = w_sumIn;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
`ifdef PIPE_ADDSUB_SAT_EN
                    r_sat <= 1'b0;
`endif
                end else if (w_load) begin
                    r_a   <= w_srcA[SRC_W-1:CHUNK];
                    r_b   <= w_srcB[SRC_W-1:CHUNK];
`ifdef PIPE_ADDSUB_SAT_EN
                    r_sat <= w_satIn;
`endif
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign out_sum   = g_stage[STAGES-1].r_sum;
    assign out_cout  = g_stage[STAGES-1].r_c;
    assign out_ovf   = g_stage[STAGES-1].g_last.r_ovf;
    assign out_zero  = g_stage[STAGES-1].g_last.r_zero;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed self-checking bench for pipe_addsub (WIDTH=32, CHUNK=8, 4 stages).
// Saturation scenarios are compiled in only with PIPE_ADDSUB_SAT_EN.
`timescale 1ns/1ps
module tb_pipe_addsub;

    logic        clock, reset_n;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [31:0] out_sum;
`ifdef PIPE_ADDSUB_SAT_EN
    logic        in_sat;
`endif

    int   numCompared   = 0;
    int   numMismatched = 0;
    int   lat;
    logic lastReady;

    pipe_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
`ifdef PIPE_ADDSUB_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Offers one beat, then counts negedges from the accept edge until out_valid.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clock);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        #1 lastReady = in_ready;
        @(posedge clock);
        lat = 0;
        do begin
            @(negedge clock);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic test_reset;
        @(negedge clock);
        @(negedge clock);
        numCompared += 6;
        if (out_valid !== 1'b0) begin numMismatched++; $display("[TB] FAIL rst_valid: got %b expected 0", out_valid); end
        if (out_sum !== 32'h0) begin numMismatched++; $display("[TB] FAIL rst_sum: got %h expected 0", out_sum); end
        if (out_cout !== 1'b0) begin numMismatched++; $display("[TB] FAIL rst_cout: got %b expected 0", out_cout); end
        if (out_ovf !== 1'b0) begin numMismatched++; $display("[TB] FAIL rst_ovf: got %b expected 0", out_ovf); end
        if (out_zero !== 1'b0) begin numMismatched++; $display("[TB] FAIL rst_zero: got %b expected 0", out_zero); end
        if (in_ready !== 1'b0) begin numMismatched++; $display("[TB] FAIL rst_in_ready: got %b expected 0", in_ready); end
        reset_n = 1'b1;
        #1;
        numCompared++;
        if (in_ready !== 1'b1) begin numMismatched++; $display("[TB] FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add_overflow;
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        numCompared += 6;
        if (lastReady !== 1'b1) begin numMismatched++; $display("[TB] FAIL addovf_accept: got %b expected 1", lastReady); end
        if (lat != 4) begin numMismatched++; $display("[TB] FAIL addovf_latency: got %0d expected 4", lat); end
        if (out_sum !== 32'h8000_0000) begin numMismatched++; $display("[TB] FAIL addovf_sum: got %h expected 80000000", out_sum); end
        if (out_cout !== 1'b0) begin numMismatched++; $display("[TB] FAIL addovf_cout: got %b expected 0", out_cout); end
        if (out_ovf !== 1'b1) begin numMismatched++; $display("[TB] FAIL addovf_ovf: got %b expected 1", out_ovf); end
        if (out_zero !== 1'b0) begin numMismatched++; $display("[TB] FAIL addovf_zero: got %b expected 0", out_zero); end
    endtask

    task automatic test_carry_ripple;
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        numCompared += 5;
        if (lat != 4) begin numMismatched++; $display("[TB] FAIL ripple_latency: got %0d expected 4", lat); end
        if (out_sum !== 32'h0000_0000) begin numMismatched++; $display("[TB] FAIL ripple_sum: got %h expected 00000000", out_sum); end
        if (out_cout !== 1'b1) begin numMismatched++; $display("[TB] FAIL ripple_cout: got %b expected 1", out_cout); end
        if (out_ovf !== 1'b0) begin numMismatched++; $display("[TB] FAIL ripple_ovf: got %b expected 0", out_ovf); end
        if (out_zero !== 1'b1) begin numMismatched++; $display("[TB] FAIL ripple_zero: got %b expected 1", out_zero); end
    endtask

    task automatic test_subtract;
        applyStimulus(32'd5, 32'd7, 1'b1);
        numCompared += 4;
        if (out_sum !== 32'hFFFF_FFFE) begin numMismatched++; $display("[TB] FAIL sub57_sum: got %h expected fffffffe", out_sum); end
        if (out_cout !== 1'b0) begin numMismatched++; $display("[TB] FAIL sub57_cout: got %b expected 0", out_cout); end
        if (out_ovf !== 1'b0) begin numMismatched++; $display("[TB] FAIL sub57_ovf: got %b expected 0", out_ovf); end
        if (out_zero !== 1'b0) begin numMismatched++; $display("[TB] FAIL sub57_zero: got %b expected 0", out_zero); end
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
        numCompared += 3;
        if (out_sum !== 32'h7FFF_FFFF) begin numMismatched++; $display("[TB] FAIL submin_sum: got %h expected 7fffffff", out_sum); end
        if (out_cout !== 1'b1) begin numMismatched++; $display("[TB] FAIL submin_cout: got %b expected 1", out_cout); end
        if (out_ovf !== 1'b1) begin numMismatched++; $display("[TB] FAIL submin_ovf: got %b expected 1", out_ovf); end
        applyStimulus(32'd7, 32'd7, 1'b1);
        numCompared += 2;
        if (out_zero !== 1'b1) begin numMismatched++; $display("[TB] FAIL sub77_zero: got %b expected 1", out_zero); end
        if (out_cout !== 1'b1) begin numMismatched++; $display("[TB] FAIL sub77_cout: got %b expected 1", out_cout); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vecA [8], vecB [8], vecSum [8];
        logic        vecSub [8];
        logic [31:0] heldSum;
        logic        holding;
        int          sent, recv, lastPop;
        vecA   = '{32'h0000_00FF, 32'h0000_FFFF, 32'h00FF_FFFF, 32'h1234_5678,
                   32'h0000_0000, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0000_0064};
        vecB   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h1111_1111,
                   32'h0000_0001, 32'h0000_0001, 32'h2152_4111, 32'h0000_0032};
        vecSub = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecSum = '{32'h0000_0100, 32'h0001_0000, 32'h0100_0000, 32'h2345_6789,
                   32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'h0000_0032};
        sent = 0; recv = 0; lastPop = -1; holding = 1'b0; heldSum = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            @(negedge clock);
            out_ready = !(cyc >= 3 && cyc <= 7);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_a = vecA[sent]; in_b = vecB[sent]; in_sub = vecSub[sent];
            end
            #1;
            if (holding) begin
                numCompared++;
                if (out_valid !== 1'b1 || out_sum !== heldSum) begin
                    numMismatched++;
                    $display("[TB] FAIL b2b_stall_stable cyc %0d: got valid %b sum %h expected valid 1 sum %h", cyc, out_valid, out_sum, heldSum);
                end
            end
            if (cyc == 3 || cyc == 4 || cyc == 7) begin
                numCompared++;
                if (in_ready !== (cyc == 3)) begin
                    numMismatched++;
                    $display("[TB] FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, (cyc == 3));
                end
            end
            if (cyc == 4) begin
                numCompared++;
                if (out_valid !== 1'b1 || out_sum !== vecSum[0]) begin
                    numMismatched++;
                    $display("[TB] FAIL b2b_first_out: got valid %b sum %h expected valid 1 sum %h", out_valid, out_sum, vecSum[0]);
                end
            end
            if (out_valid && out_ready) begin
                numCompared++;
                if (out_sum !== vecSum[recv]) begin
                    numMismatched++;
                    $display("[TB] FAIL b2b_order beat %0d: got %h expected %h", recv, out_sum, vecSum[recv]);
                end
                recv++;
                lastPop = cyc;
            end
            holding = out_valid && !out_ready;
            heldSum = out_sum;
            if (in_valid && in_ready) sent++;
            if (cyc == 11) begin
                numCompared++;
                if (sent != 8) begin numMismatched++; $display("[TB] FAIL b2b_full_rate: got %0d sent expected 8", sent); end
            end
        end
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        numCompared += 2;
        if (recv != 8) begin numMismatched++; $display("[TB] FAIL b2b_count: got %0d expected 8", recv); end
        if (lastPop != 15) begin numMismatched++; $display("[TB] FAIL b2b_last_pop_cycle: got %0d expected 15", lastPop); end
    endtask

    task automatic test_reset_inflight;
        @(negedge clock); out_ready = 1'b1;
        in_valid = 1'b1; in_sub = 1'b0; in_a = 32'h0000_0010; in_b = 32'h0000_0001;
        @(negedge clock); in_a = 32'h0000_0020;
        @(negedge clock); in_a = 32'h0000_0030;
        @(negedge clock); in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        numCompared += 6;
        if (out_valid !== 1'b0) begin numMismatched++; $display("[TB] FAIL flight_rst_valid: got %b expected 0", out_valid); end
        if (out_sum !== 32'h0) begin numMismatched++; $display("[TB] FAIL flight_rst_sum: got %h expected 0", out_sum); end
        if (out_cout !== 1'b0) begin numMismatched++; $display("[TB] FAIL flight_rst_cout: got %b expected 0", out_cout); end
        if (out_ovf !== 1'b0) begin numMismatched++; $display("[TB] FAIL flight_rst_ovf: got %b expected 0", out_ovf); end
        if (out_zero !== 1'b0) begin numMismatched++; $display("[TB] FAIL flight_rst_zero: got %b expected 0", out_zero); end
        if (in_ready !== 1'b0) begin numMismatched++; $display("[TB] FAIL flight_rst_in_ready: got %b expected 0", in_ready); end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(32'h0000_1000, 32'h0000_0234, 1'b0);
        numCompared += 2;
        if (lat != 4) begin numMismatched++; $display("[TB] FAIL flight_latency: got %0d expected 4", lat); end
        if (out_sum !== 32'h0000_1234) begin numMismatched++; $display("[TB] FAIL flight_sum: got %h expected 00001234", out_sum); end
    endtask

`ifdef PIPE_ADDSUB_SAT_EN
    task automatic test_saturation;
        in_sat = 1'b1;
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        numCompared += 4;
        if (out_sum !== 32'h7FFF_FFFF) begin numMismatched++; $display("[TB] FAIL sat_pos_sum: got %h expected 7fffffff", out_sum); end
        if (out_ovf !== 1'b1) begin numMismatched++; $display("[TB] FAIL sat_pos_ovf: got %b expected 1", out_ovf); end
        if (out_cout !== 1'b0) begin numMismatched++; $display("[TB] FAIL sat_pos_cout: got %b expected 0", out_cout); end
        if (out_zero !== 1'b0) begin numMismatched++; $display("[TB] FAIL sat_pos_zero: got %b expected 0", out_zero); end
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
        numCompared += 2;
        if (out_sum !== 32'h8000_0000) begin numMismatched++; $display("[TB] FAIL sat_neg_sum: got %h expected 80000000", out_sum); end
        if (out_ovf !== 1'b1) begin numMismatched++; $display("[TB] FAIL sat_neg_ovf: got %b expected 1", out_ovf); end
        in_sat = 1'b0;
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        numCompared++;
        if (out_sum !== 32'h8000_0000) begin numMismatched++; $display("[TB] FAIL wrap_pos_sum: got %h expected 80000000", out_sum); end
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1);
        numCompared++;
        if (out_sum !== 32'h7FFF_FFFF) begin numMismatched++; $display("[TB] FAIL wrap_neg_sum: got %h expected 7fffffff", out_sum); end
    endtask
`endif

    initial begin
        reset_n = 1'b1; in_valid = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; lat = 0; lastReady = 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
        in_sat = 1'b0;
`endif
        #2 reset_n = 1'b0;
        test_reset();
        test_add_overflow();
        test_carry_ripple();
        test_subtract();
        test_back_to_back();
        test_reset_inflight();
`ifdef PIPE_ADDSUB_SAT_EN
        test_saturation();
`endif
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
